// File: rtl/rect_fill_engine_pkg.sv
// Shared frame-buffer geometry, colours, FSM encoding and helpers.
// Included by every rect_fill_engine file.
package rect_fill_engine_pkg;

  localparam int FB_AW       = 15;
  localparam int FB_DW       = 3;
  localparam int FB_SCREEN_X = 176;
  localparam int FB_GRID_W   = 80;
  localparam int FB_GRID_H   = 60;

  localparam logic [2:0] RED_VGA   = 3'b100;
  localparam logic [2:0] GREEN_VGA = 3'b010;
  localparam logic [2:0] BLUE_VGA  = 3'b001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [6:0] w_eff;
    logic [5:0] h_eff;
    logic       empty;
  } clip_t;

  // Multiply by a constant stride as a sum of shifted copies.
  function automatic logic [31:0] shift_add(
    input logic [31:0] a,
    input logic [31:0] k
  );
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

  // Rooms go negative (bit 7) once the origin lies past the grid.
  function automatic clip_t clip_rect(
    input logic [6:0] x0,
    input logic [5:0] y0,
    input logic [6:0] w,
    input logic [5:0] h,
    input logic [7:0] gw,
    input logic [7:0] gh
  );
    logic [7:0] room_x;
    logic [7:0] room_y;
    clip_t      c;
    room_x  = gw - {1'b0, x0};
    room_y  = gh - {2'b00, y0};
    c.w_eff = ({1'b0, w} < room_x) ? w : room_x[6:0];
    c.h_eff = ({2'b00, h} < room_y) ? h : room_y[5:0];
    c.empty = (w == '0) || (h == '0)
           || (room_x == '0) || room_x[7]
           || (room_y == '0) || (room_y[7:6] != 2'b00);
    return c;
  endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command handshake plus frame-buffer write port of rect_fill_engine.
// The outline signal exists only with RECT_FILL_OUTLINE_EN.
interface rect_fill_engine_if
  import rect_fill_engine_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
);

  logic          start;
  logic [6:0]    x0;
  logic [5:0]    y0;
  logic [6:0]    w;
  logic [5:0]    h;
  logic [DW-1:0] color;
`ifdef RECT_FILL_OUTLINE_EN
  logic          outline;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;

  modport slave (
`ifdef RECT_FILL_OUTLINE_EN
    input  outline,
`endif
    input  start, x0, y0, w, h, color,
    output busy, done,
    output mem_px_addr, mem_px_data, px_wr
  );

  modport master (
`ifdef RECT_FILL_OUTLINE_EN
    output outline,
`endif
    output start, x0, y0, w, h, color,
    input  busy, done,
    input  mem_px_addr, mem_px_data, px_wr
  );

endinterface

// File: rtl/rect_fill_engine_raster_walker.sv
// Raster walker: column/row counters, running row base, last/border flags.
// border_o exists only with RECT_FILL_OUTLINE_EN.
module raster_walker
  import rect_fill_engine_pkg::*;
#(
  parameter int AW       = FB_AW,
  parameter int SCREEN_X = FB_SCREEN_X
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [6:0]    w_eff_i,
  input  logic [5:0]    h_eff_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] addr_o,
`ifdef RECT_FILL_OUTLINE_EN
  output logic          border_o,
`endif
  output logic          last_o
);

  logic [6:0]    cx_q;
  logic [5:0]    cy_q;
  logic [6:0]    wl_q;
  logic [5:0]    hl_q;
  logic [AW-1:0] row_q;
  logic          row_end;

  assign row_end = (cx_q == wl_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q  <= '0;
      cy_q  <= '0;
      wl_q  <= '0;
      hl_q  <= '0;
      row_q <= '0;
    end else if (load_i) begin
      cx_q  <= '0;
      cy_q  <= '0;
      wl_q  <= w_eff_i - 7'd1;
      hl_q  <= h_eff_i - 6'd1;
      row_q <= base_i;
    end else if (step_i) begin
      if (row_end) begin
        cx_q  <= '0;
        cy_q  <= cy_q + 6'd1;
        row_q <= row_q + AW'(SCREEN_X);
      end else begin
        cx_q  <= cx_q + 7'd1;
      end
    end
  end

  assign addr_o = row_q + AW'(cx_q);
  assign last_o = row_end && (cy_q == hl_q);

`ifdef RECT_FILL_OUTLINE_EN
  assign border_o = (cx_q == '0) || row_end
                 || (cy_q == '0) || (cy_q == hl_q);
`endif

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser driving the frame-buffer write port.
// Optional outline mode is enabled by defining RECT_FILL_OUTLINE_EN.
module rect_fill_engine
  import rect_fill_engine_pkg::*;
#(
  parameter int AW       = FB_AW,
  parameter int DW       = FB_DW,
  parameter int SCREEN_X = FB_SCREEN_X,
  parameter int GRID_W   = FB_GRID_W,
  parameter int GRID_H   = FB_GRID_H
) (
  input logic               clk,
  input logic               rst,
  rect_fill_engine_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic [6:0]    x0_q;
  logic [5:0]    y0_q;
  logic [6:0]    w_q;
  logic [5:0]    h_q;
  logic [DW-1:0] color_q;
`ifdef RECT_FILL_OUTLINE_EN
  logic          outline_q;
  logic          border;
`endif

  logic          busy_q;
  logic          done_q;
  logic          px_wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  logic          st_idle, st_clip, st_fill, st_done;
  logic          accept, load, last, wr_en;
  logic [AW-1:0] base;
  logic [AW-1:0] walk_addr;
  clip_t         clip;

  assign st_idle = (state_q == ST_IDLE);
  assign st_clip = (state_q == ST_CLIP);
  assign st_fill = (state_q == ST_FILL);
  assign st_done = (state_q == ST_DONE);
  assign accept  = st_idle && bus.start;

  assign clip = clip_rect(x0_q, y0_q, w_q, h_q,
                          8'(GRID_W), 8'(GRID_H));

  // No multiplier: the stride is a constant shift-add.
  assign base = AW'(shift_add(32'(y0_q), 32'(SCREEN_X)))
              + AW'(x0_q);

  assign load = st_clip && !clip.empty;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: if (bus.start) state_d = ST_CLIP;
      st_clip: state_d = clip.empty ? ST_DONE : ST_FILL;
      st_fill: if (last) state_d = ST_DONE;
      st_done: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else if (accept) begin
      x0_q      <= bus.x0;
      y0_q      <= bus.y0;
      w_q       <= bus.w;
      h_q       <= bus.h;
      color_q   <= bus.color;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q <= bus.outline;
`endif
    end
  end

  raster_walker #(
    .AW       (AW),
    .SCREEN_X (SCREEN_X)
  ) u_walker (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (st_fill),
    .w_eff_i  (clip.w_eff),
    .h_eff_i  (clip.h_eff),
    .base_i   (base),
    .addr_o   (walk_addr),
`ifdef RECT_FILL_OUTLINE_EN
    .border_o (border),
`endif
    .last_o   (last)
  );

`ifdef RECT_FILL_OUTLINE_EN
  assign wr_en = st_fill && (!outline_q || border);
`else
  assign wr_en = st_fill;
`endif

  // Address and data only move on a real write, so they hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      px_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= st_done;
      px_wr_q <= wr_en;
      if (wr_en) begin
        addr_q <= walk_addr;
        data_q <= color_q;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.px_wr       = px_wr_q;
  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_data = data_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomised self-checking bench for rect_fill_engine.
// Outline scenarios run when RECT_FILL_OUTLINE_EN is defined.
module tb_rect_fill_engine;
  import rect_fill_engine_pkg::*;

`ifdef RECT_FILL_OUTLINE_EN
  localparam bit OUTLINE_BUILD = 1'b1;
`else
  localparam bit OUTLINE_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rect_fill_engine_if #(.AW(FB_AW), .DW(FB_DW)) bus();

  rect_fill_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int exp_addr[$];
  int exp_j[$];
  int exp_n;
  int cur_color;
  bit cur_ol;

  int cap_addr[$];
  int cap_data[$];
  int cap_j[$];
  int done_at;
  int done_cnt;
  int busy_err;
  logic busy0;
  logic busy_at_done;

  // Reference: visit every visible cell of the clipped rectangle in
  // raster order; each visit takes one cycle, starting two edges in.
  task automatic build_exp(input int x0, input int y0,
                           input int w, input int h, input bit ol);
    int xe, ye, n;
    exp_addr.delete();
    exp_j.delete();
    xe = (x0 + w < FB_GRID_W) ? x0 + w : FB_GRID_W;
    ye = (y0 + h < FB_GRID_H) ? y0 + h : FB_GRID_H;
    n = 0;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        if (!ol || x == x0 || x == xe - 1 ||
            y == y0 || y == ye - 1) begin
          exp_addr.push_back(x + y * FB_SCREEN_X);
          exp_j.push_back(2 + n);
        end
        n++;
      end
    end
    exp_n = n;
  endtask

  task automatic issue(input int x0, input int y0, input int w,
                       input int h, input int c, input int ol);
    bus.x0    = 7'(x0);
    bus.y0    = 6'(y0);
    bus.w     = 7'(w);
    bus.h     = 6'(h);
    bus.color = 3'(c);
`ifdef RECT_FILL_OUTLINE_EN
    bus.outline = (ol != 0);
`endif
    cur_ol    = (ol != 0) && OUTLINE_BUILD;
    cur_color = c;
    build_exp(x0, y0, w, h, cur_ol);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Records the write stream and done/busy behaviour after a start edge.
  task automatic capture(input int budget, input bit stop_at_done,
                         input int inject_j);
    cap_addr.delete();
    cap_data.delete();
    cap_j.delete();
    done_at  = -1;
    done_cnt = 0;
    busy_err = 0;
    busy_at_done = 1'b1;
    busy0    = bus.busy;
    for (int j = 1; j <= budget; j++) begin
      @(posedge clk);
      #1;
      if (bus.px_wr) begin
        cap_addr.push_back(int'(bus.mem_px_addr));
        cap_data.push_back(int'(bus.mem_px_data));
        cap_j.push_back(j);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = j;
          busy_at_done = bus.busy;
        end
      end else if (done_at < 0 && !bus.busy) begin
        busy_err++;
      end
      if (j == inject_j) begin
        bus.x0 = 7'd40;
        bus.y0 = 6'd20;
        bus.w  = 7'd9;
        bus.h  = 6'd9;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (stop_at_done && done_at >= 0) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.px_wr !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: wr=%b busy=%b done=%b want 0 0 0",
               bus.px_wr, bus.busy, bus.done);
    end
    vectors++;
    if (bus.mem_px_addr !== '0 || bus.mem_px_data !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%0d data=%0d want 0 0",
               bus.mem_px_addr, bus.mem_px_data);
    end
  endtask

  task automatic test_solid();
    int want[6] = '{530, 531, 532, 706, 707, 708};
    issue(2, 3, 3, 2, int'(RED_VGA), 0);
    capture(16, 1'b0, 0);
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL solid_busy: got %b want 1", busy0);
    end
    vectors++;
    if (cap_addr.size() != 6) begin
      miscompares++;
      $display("FAIL solid_count: got %0d want 6", cap_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (cap_addr[i] != want[i] || cap_data[i] != 4 ||
            cap_j[i] != 2 + i) begin
          miscompares++;
          $display("FAIL solid_wr%0d: got a=%0d d=%0d j=%0d want %0d 4 %0d",
                   i, cap_addr[i], cap_data[i], cap_j[i], want[i], 2 + i);
        end
      end
    end
    vectors++;
    if (done_at != 8 || done_cnt != 1 || busy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL solid_done: got at=%0d n=%0d busy=%b want 8 1 0",
               done_at, done_cnt, busy_at_done);
    end
    vectors++;
    if (bus.mem_px_addr !== 15'd708 || bus.mem_px_data !== 3'b100) begin
      miscompares++;
      $display("FAIL solid_hold: got a=%0d d=%0d want 708 4",
               bus.mem_px_addr, bus.mem_px_data);
    end
  endtask

  task automatic test_clip();
    issue(78, 59, 5, 4, int'(GREEN_VGA), 0);
    capture(12, 1'b0, 0);
    vectors++;
    if (cap_addr.size() != 2) begin
      miscompares++;
      $display("FAIL clip_count: got %0d want 2", cap_addr.size());
    end else begin
      vectors++;
      if (cap_addr[0] != 10462 || cap_addr[1] != 10463) begin
        miscompares++;
        $display("FAIL clip_addr: got %0d %0d want 10462 10463",
                 cap_addr[0], cap_addr[1]);
      end
    end
    vectors++;
    if (done_at != 4 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL clip_done: got at=%0d n=%0d want 4 1",
               done_at, done_cnt);
    end
  endtask

  task automatic test_empty();
    issue(10, 10, 0, $urandom_range(1, 63), int'(BLUE_VGA), 0);
    capture(10, 1'b0, 0);
    vectors++;
    if (cap_addr.size() != 0) begin
      miscompares++;
      $display("FAIL empty_count: got %0d want 0", cap_addr.size());
    end
    vectors++;
    if (busy0 !== 1'b1 || busy_err != 0 || busy_at_done !== 1'b0 ||
        done_at != 2 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL empty_timing: got b0=%b berr=%0d bd=%b at=%0d n=%0d want 1 0 0 2 1",
               busy0, busy_err, busy_at_done, done_at, done_cnt);
    end
  endtask

  task automatic test_ignore_start();
    issue(5, 5, 3, 2, int'(RED_VGA), 0);
    capture(30, 1'b0, 3);
    vectors++;
    if (cap_addr.size() != 6 || done_cnt != 1 || done_at != 8) begin
      miscompares++;
      $display("FAIL ignore_start: got n=%0d dones=%0d at=%0d want 6 1 8",
               cap_addr.size(), done_cnt, done_at);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    int dones = 0;
    issue(0, 0, 4, 4, int'(GREEN_VGA), 0);
    for (int j = 0; j < 10 && seen < 3; j++) begin
      @(posedge clk);
      #1;
      if (bus.px_wr) seen++;
    end
    vectors++;
    if (seen != 3) begin
      miscompares++;
      $display("FAIL abort_reach: got %0d writes want 3", seen);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.px_wr !== 1'b0 || bus.busy !== 1'b0 ||
        bus.mem_px_addr !== '0 || bus.mem_px_data !== '0) begin
      miscompares++;
      $display("FAIL abort_async: wr=%b busy=%b a=%0d d=%0d want 0",
               bus.px_wr, bus.busy, bus.mem_px_addr, bus.mem_px_data);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (bus.done) dones++;
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort_done: got %0d want 0", dones);
    end
    issue(1, 1, 2, 2, int'(BLUE_VGA), 0);
    capture(12, 1'b1, 0);
    vectors++;
    if (cap_addr.size() != 4 || cap_addr[0] != 177 ||
        cap_addr[3] != 354 || done_at != 6) begin
      miscompares++;
      $display("FAIL abort_rerun: got n=%0d at=%0d want 4 6",
               cap_addr.size(), done_at);
    end
  endtask

  task automatic test_back_to_back();
    issue(70, 0, 15, 2, int'(RED_VGA), 0);
    capture(40, 1'b1, 0);
    issue(0, 58, 3, 5, int'(GREEN_VGA), 0);
    capture(20, 1'b1, 0);
    vectors++;
    if (busy0 !== 1'b1 || cap_addr.size() != exp_addr.size() ||
        done_at != 2 + exp_n) begin
      miscompares++;
      $display("FAIL b2b: got b=%b n=%0d at=%0d want 1 %0d %0d",
               busy0, cap_addr.size(), done_at,
               exp_addr.size(), 2 + exp_n);
    end else begin
      for (int i = 0; i < cap_addr.size(); i++) begin
        vectors++;
        if (cap_addr[i] != exp_addr[i]) begin
          miscompares++;
          $display("FAIL b2b_wr%0d: got %0d want %0d",
                   i, cap_addr[i], exp_addr[i]);
        end
      end
    end
  endtask

`ifdef RECT_FILL_OUTLINE_EN
  task automatic test_outline();
    int hit = 0;
    issue(0, 0, 4, 3, int'(RED_VGA), 1);
    capture(20, 1'b0, 0);
    foreach (cap_addr[i]) begin
      if (cap_addr[i] == 177 || cap_addr[i] == 178) hit++;
    end
    vectors++;
    if (cap_addr.size() != 10 || hit != 0) begin
      miscompares++;
      $display("FAIL outline_wr: got n=%0d interior=%0d want 10 0",
               cap_addr.size(), hit);
    end
    vectors++;
    if (done_at != 14 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL outline_done: got at=%0d n=%0d want 14 1",
               done_at, done_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int x0, y0, w, h, c, ol;
      x0 = $urandom_range(0, 84);
      y0 = $urandom_range(0, 63);
      w  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      h  = $urandom_range(0, 12);
      c  = $urandom_range(1, 7);
      ol = $urandom_range(0, 1);
      issue(x0, y0, w, h, c, ol);
      capture(exp_n + 8, 1'b1, 0);
      vectors++;
      if (cap_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL rnd%0d_count: got %0d want %0d (x0=%0d y0=%0d w=%0d h=%0d)",
                 t, cap_addr.size(), exp_addr.size(), x0, y0, w, h);
      end else begin
        for (int i = 0; i < cap_addr.size(); i++) begin
          vectors++;
          if (cap_addr[i] != exp_addr[i] || cap_j[i] != exp_j[i] ||
              cap_data[i] != cur_color) begin
            miscompares++;
            $display("FAIL rnd%0d_wr%0d: got a=%0d j=%0d d=%0d want %0d %0d %0d",
                     t, i, cap_addr[i], cap_j[i], cap_data[i],
                     exp_addr[i], exp_j[i], cur_color);
          end
        end
      end
      vectors++;
      if (done_at != 2 + exp_n || busy_err != 0 ||
          busy_at_done !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got at=%0d berr=%0d bd=%b want %0d 0 0",
                 t, done_at, busy_err, busy_at_done, 2 + exp_n);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.w     = '0;
    bus.h     = '0;
    bus.color = '0;
`ifdef RECT_FILL_OUTLINE_EN
    bus.outline = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_solid();
    test_clip();
    test_empty();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef RECT_FILL_OUTLINE_EN
    test_outline();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Draw engine that sits upstream of the dual-port frame buffer, on its write port. It takes one rectangle command per handshake and rasterises it into the 80×60 cell grid at one pixel per clock. It drives the buffer's `addr_in`/`data_in`/`regwrite` write port, so the game logic issues shape-level commands instead of individual pixel writes. Buffer addressing is `x + y*SCREEN_X`, matching how the display side reads the buffer.

## Interface
Parameters:
- `AW`, 15: frame-buffer address width.
- `DW`, 3: pixel width, RGB111.
- `SCREEN_X`, 176: row stride in buffer words.
- `GRID_W`, 80: visible cells per row (640/8).
- `GRID_H`, 60: visible rows (480/8).

Ports:
- `clk` in 1: pixel clock, 25 MHz domain, shared with the frame buffer.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe, sampled only in IDLE.
- `x0` in 7: left cell column.
- `y0` in 6: top cell row.
- `w` in 7: width in cells.
- `h` in 6: height in cells.
- `color` in DW: fill value.
- `busy` out 1: high while a command is in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_px_addr` out AW: buffer write address.
- `mem_px_data` out DW: buffer write data.
- `px_wr` out 1: buffer write enable.

## Operation
- States and transitions:
  - IDLE → CLIP when `start`=1.
  - CLIP → FILL, or CLIP → DONE when the clipped area is empty.
  - FILL → DONE after the last cell.
  - DONE → IDLE.
- IDLE: `start`=1 latches `x0`, `y0`, `w`, `h`, `color`.
- CLIP (1 cycle), computed in 8-bit arithmetic to avoid overflow:
  - `w_eff = min(w, GRID_W-x0)`
  - `h_eff = min(h, GRID_H-y0)`
  - The area is empty when `w`=0, `h`=0, `x0`≥GRID_W or `y0`≥GRID_H.
  - `row_base = y0*SCREEN_X + x0` is computed with shift-add (176 = 128+32+16). No generic multiplier.
- FILL: raster order, left to right then top to bottom.
  - Column counter `cx` runs 0..w_eff-1; row counter `cy` runs 0..h_eff-1.
  - `mem_px_addr = row_base + cx`.
  - At row end, `row_base += SCREEN_X` and `cx` returns to 0.
- DONE: `done`=1 for exactly one cycle.
- `start` while `busy`=1 is ignored and not queued.
- Outputs are registered.
- Reset values: all outputs 0, state IDLE.
- Asserting `rst` mid-FILL aborts the command immediately: `px_wr` falls asynchronously and no `done` is produced.

## Timing
- `start` sampled high at edge k:
  - `busy`=1 after edge k.
  - First `px_wr`=1 after edge k+2.
  - Writes occupy N = w_eff·h_eff consecutive cycles, with no gaps in solid mode.
- `done`=1 after edge k+2+N, and `busy`=0 in that same cycle.
- Empty area: no writes, `done` after edge k+2.
- The next command can be accepted the cycle after `done`.
- `mem_px_data` is stable for the whole command.
- `mem_px_addr` and `mem_px_data` are held at their last value when `px_wr`=0.

## Configuration
- Macro `RECT_FILL_OUTLINE_EN`.
- Defined:
  - Adds an input port `outline` (1 bit), latched with the command.
  - When `outline`=1, the walker still visits all N positions, but `px_wr` is asserted only when `cx`∈{0, w_eff-1} or `cy`∈{0, h_eff-1}.
  - Command duration is unchanged.
- Undefined: the `outline` port is absent and every command is a solid fill.

## Structure
- Shared header `vga_pkg.vh` holds:
  - `AW`, `DW`, `SCREEN_X`, `GRID_W`, `GRID_H`.
  - Colour constants `RED_VGA`=3'b100, `GREEN_VGA`=3'b010, `BLUE_VGA`=3'b001.
  - The state encoding of this block.
- One natural sub-module: `raster_walker`.
  - Holds the `cx`/`cy`/`row_base` counters plus the last-cell and border flags.
  - The top level holds the FSM, clipping logic and output registers.

## Test plan
- Solid fill `x0`=2, `y0`=3, `w`=3, `h`=2, `color`=RED:
  - Exactly 6 writes, to addresses 530, 531, 532, 706, 707, 708, all with data 3'b100.
  - `done` arrives one cycle after the 6th write.
- Clipping `x0`=78, `y0`=59, `w`=5, `h`=4: exactly 2 writes, to addresses 10462 and 10463; `done` after edge k+4.
- `w`=0 with any other operands: zero writes; `busy` high for 2 cycles; `done` after edge k+2.
- Second `start` pulse asserted mid-fill: ignored; write count equals that of the first command only; no second `done`.
- `rst` pulled low during write 3 of a 4×4 fill:
  - Outputs drop to 0 without waiting for a clock edge; no `done`.
  - After release, a new command runs normally.
- With `RECT_FILL_OUTLINE_EN`, `outline`=1, `x0`=0, `y0`=0, `w`=4, `h`=3:
  - 10 writes; addresses 177 and 178 are never written.
  - `done` after edge k+14.
